ram_arbiter: RTL and testbench

//  Shares the single-port 2Kx8 block RAM between two requesters: port A (Z80 bus, normally

---
 rtl/ram_arb_pkg.sv | 8 +
 rtl/ram_arb_pick.sv | 26 ++
 rtl/ram_arbiter.sv | 96 +++++++++
 tb/tb_ram_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: state encoding, port indices and default widths shared by ram_arbiter and ram_arb_pick
package ram_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;
endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational grant select and next starvation count.
// RAM_ARB_RR_EN defined selects round-robin; otherwise A has fixed priority with a B starvation limit.
module ram_arb_pick import ram_arb_pkg::*; #(
  parameter int STARVE_MAX = 4
) (
  input  logic       i_a_req,
  input  logic       i_b_req,
  input  logic       i_last_winner,
  input  logic [3:0] i_starve_cnt,
  output logic       o_winner,
  output logic [3:0] o_starve_next
);
  logic w_tie_b;
  logic w_unused;
`ifdef RAM_ARB_RR_EN
  assign w_unused = ^{i_starve_cnt, STARVE_MAX[0]};
  assign w_tie_b = (i_last_winner == PORT_A);
  assign o_starve_next = '0;
`else
  assign w_unused = i_last_winner;
  assign w_tie_b = (i_starve_cnt == 4'(STARVE_MAX));
  // any B grant or an absent B request clears the count; an A grant over a waiting B bumps it
  assign o_starve_next = (!i_b_req || o_winner == PORT_B) ? 4'd0 : i_starve_cnt + 4'd1;
`endif
  always_comb o_winner = !i_a_req ? PORT_B : !i_b_req ? PORT_A : w_tie_b ? PORT_B : PORT_A;
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port block RAM between port A (favoured) and port B, one access per 3 cycles.
// Define RAM_ARB_RR_EN for round-robin arbitration instead of fixed A priority.
module ram_arbiter #(
  parameter int ADDR_W     = ram_arb_pkg::ADDR_W,
  parameter int DATA_W     = ram_arb_pkg::DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_ack,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_wre,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              ram_reset,
  output logic              busy
);
  import ram_arb_pkg::*;
  state_t            r_state;
  state_t            w_next;
  logic              r_winner;
  logic              r_wre;
  logic [ADDR_W-1:0] r_ad;
  logic [DATA_W-1:0] r_din;
  logic [DATA_W-1:0] r_a_rdata;
  logic [DATA_W-1:0] r_b_rdata;
  logic [3:0]        r_starve_cnt;
  logic [3:0]        w_starve_next;
  logic              w_winner;
  logic              w_grant;
  logic              w_rd_done;
  ram_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .i_a_req       (a_req),
    .i_b_req       (b_req),
    .i_last_winner (r_winner),
    .i_starve_cnt  (r_starve_cnt),
    .o_winner      (w_winner),
    .o_starve_next (w_starve_next)
  );
  assign w_grant   = (r_state == IDLE) && (a_req || b_req);
  assign w_rd_done = (r_state == DONE) && !r_wre;
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb w_next = (r_state == IDLE) ? (w_grant ? ISSUE : IDLE) : (r_state == ISSUE) ? DONE : IDLE;
  // r_winner doubles as the last-winner history; resetting it to B lets A take the first round-robin tie
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_winner     <= PORT_B;
      r_wre        <= 1'b0;
      r_ad         <= '0;
      r_din        <= '0;
      r_a_rdata    <= '0;
      r_b_rdata    <= '0;
      r_starve_cnt <= '0;
    end else begin
      if (w_grant) begin
        r_winner <= w_winner;
        r_wre    <= w_winner ? b_we : a_we;
        r_ad     <= w_winner ? b_addr : a_addr;
        r_din    <= w_winner ? b_wdata : a_wdata;
      end
      if (r_state == IDLE) r_starve_cnt <= w_starve_next;
      if (w_rd_done && r_winner == PORT_A) r_a_rdata <= ram_dout;
      if (w_rd_done && r_winner == PORT_B) r_b_rdata <= ram_dout;
    end
  end
  // read data bypasses the capture register during DONE so it is valid alongside ack
  always_comb begin
    ram_ce    = (r_state == ISSUE);
    ram_oce   = 1'b1;
    ram_wre   = r_wre;
    ram_ad    = r_ad;
    ram_din   = r_din;
    ram_reset = ~reset_n;
    busy      = (r_state != IDLE);
    a_ack     = (r_state == DONE) && (r_winner == PORT_A);
    b_ack     = (r_state == DONE) && (r_winner == PORT_B);
    a_rdata   = (w_rd_done && r_winner == PORT_A) ? ram_dout : r_a_rdata;
    b_rdata   = (w_rd_done && r_winner == PORT_B) ? ram_dout : r_b_rdata;
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench for ram_arbiter with a behavioural block RAM model.
module tb_ram_arbiter;
  typedef struct packed {
    logic       port;
    logic       we;
    logic [7:0] data;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [10:0] a_addr = '0, b_addr = '0;
  logic [7:0]  a_wdata = '0, b_wdata = '0;
  logic [7:0]  a_rdata, b_rdata, ram_din, ram_dout;
  logic        a_ack, b_ack, ram_ce, ram_oce, ram_wre, ram_reset, busy;
  logic [10:0] ram_ad;
  logic [7:0]  mem [2048];
  logic [7:0]  ref_mem [2048];
  exp_t        sb [$];
  int          n_checks = 0, n_errors = 0;
  int          cyc_no = 0, ce_cnt = 0, a_acks = 0, b_acks = 0;
  int          ack_cyc [2];
  int          issue_cyc [2];
  logic        prev_ce = 1'b0, hold = 1'b0;
  logic        last_wre;
  logic [10:0] last_ad;
  logic [7:0]  last_din;
  always #5 clk = ~clk;
  ram_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(a_rdata), .a_ack(a_ack),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(b_rdata), .b_ack(b_ack),
    .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_wre(ram_wre), .ram_ad(ram_ad), .ram_din(ram_din),
    .ram_dout(ram_dout), .ram_reset(ram_reset), .busy(busy)
  );
  always @(posedge clk) begin
    if (ram_ce && ram_wre) mem[ram_ad] <= ram_din;
    ram_dout <= ram_reset ? 8'h00 : (ram_ce && !ram_wre) ? mem[ram_ad] : ram_dout;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    logic got_a, got_b, port;
    exp_t e;
    @(negedge clk);
    cyc_no++;
    if (ram_ce) begin
      ce_cnt++;
      check("ce_one_cycle", {31'd0, prev_ce}, 0);
      last_wre = ram_wre;
      last_ad  = ram_ad;
      last_din = ram_din;
    end
    prev_ce = ram_ce;
    got_a = a_ack;
    got_b = b_ack;
    if (got_a || got_b) begin
      check("one_ack", {31'd0, got_a & got_b}, 0);
      port = got_b;
      if (sb.size() == 0) check("sb_unexpected_ack", sb.size(), 1);
      else begin
        e = sb.pop_front();
        check("ack_port", {31'd0, port}, {31'd0, e.port});
        if (!e.we) check("rdata", {24'd0, port ? b_rdata : a_rdata}, {24'd0, e.data});
      end
      ack_cyc[port] = cyc_no;
      if (port) b_acks++;
      else a_acks++;
    end
    @(posedge clk);
    #1;
    if (!hold && got_a) a_req = 1'b0;
    if (!hold && got_b) b_req = 1'b0;
  endtask
  task automatic issue(input logic port, input logic we, input logic [10:0] addr, input logic [7:0] data);
    exp_t e;
    e.port = port;
    e.we   = we;
    e.data = we ? 8'h00 : ref_mem[addr];
    if (we) ref_mem[addr] = data;
    sb.push_back(e);
    issue_cyc[port] = cyc_no;
    if (!port) begin
      a_we = we; a_addr = addr; a_wdata = data; a_req = 1'b1;
    end else begin
      b_we = we; b_addr = addr; b_wdata = data; b_req = 1'b1;
    end
  endtask
  task automatic run(input int n);
    int start = a_acks + b_acks;
    int budget = 0;
    while (a_acks + b_acks - start < n && budget < 8 * n + 10) begin
      tick;
      budget++;
    end
    check("ack_count", a_acks + b_acks - start, n);
  endtask
  task automatic do_reset;
    reset_n = 1'b0;
    a_req = 1'b0;
    b_req = 1'b0;
    tick;
    tick;
    check("rst_ctl", {25'd0, ram_ce, ram_wre, a_ack, b_ack, busy, ram_oce, ram_reset}, 32'b0000011);
    check("rst_ad_din", {13'd0, ram_ad, ram_din}, 0);
    check("rst_rdata", {16'd0, a_rdata, b_rdata}, 0);
    reset_n = 1'b1;
    tick;
  endtask
  initial begin
    int ce0, a0, b0, n0;
    logic p;
    do_reset;
    issue(1'b0, 1'b1, 11'h010, 8'h11); run(1);
    issue(1'b0, 1'b1, 11'h020, 8'h22); run(1);
    ce0 = ce_cnt; b0 = b_acks;
    issue(1'b0, 1'b1, 11'h7FF, 8'hA5); run(1);
    check("t1_wr_latency", ack_cyc[0] - issue_cyc[0], 3);
    issue(1'b0, 1'b0, 11'h7FF, 8'h00); run(1);
    check("t1_rd_latency", ack_cyc[0] - issue_cyc[0], 3);
    check("t1_rdata", {24'd0, a_rdata}, 32'hA5);
    check("t1_ce_count", ce_cnt - ce0, 2);
    check("t1_no_b_ack", b_acks - b0, 0);
    do_reset;
    issue(1'b0, 1'b0, 11'h010, 8'h00);
    issue(1'b1, 1'b0, 11'h020, 8'h00);
    run(2);
    check("t2_b_gap", ack_cyc[1] - ack_cyc[0], 3);
    check("t2_b_rdata", {24'd0, b_rdata}, 32'h22);
    check("t2_a_hold", {24'd0, a_rdata}, 32'h11);
    issue(1'b0, 1'b1, 11'h030, 8'h77); run(1);
    check("t6_a_hold_after_wr", {24'd0, a_rdata}, 32'h11);
    ce0 = ce_cnt;
    issue(1'b1, 1'b1, 11'h000, 8'h5A); run(1);
    check("t4_issue_bus", {12'd0, last_wre, last_ad, last_din}, {12'd0, 1'b1, 11'h000, 8'h5A});
    check("t4_ce_count", ce_cnt - ce0, 1);
    issue(1'b1, 1'b0, 11'h000, 8'h00); run(1);
    check("t4_b_rdata", {24'd0, b_rdata}, 32'h5A);
    check("t4_a_hold", {24'd0, a_rdata}, 32'h11);
    do_reset;
    b0 = b_acks;
    for (int i = 0; i < 10; i++) begin
`ifdef RAM_ARB_RR_EN
      p = (i % 2) == 1;
`else
      p = (i % 5) == 4;
`endif
      if (p) issue(1'b1, 1'b0, 11'h020, 8'h00);
      else issue(1'b0, 1'b0, 11'h010, 8'h00);
    end
    hold = 1'b1;
    run(10);
    hold = 1'b0;
    a_req = 1'b0;
    b_req = 1'b0;
`ifdef RAM_ARB_RR_EN
    check("t3_b_grants", b_acks - b0, 5);
`else
    check("t3_b_grants", b_acks - b0, 2);
`endif
    n0 = a_acks + b_acks;
    repeat (4) tick;
    check("t3_quiet", a_acks + b_acks - n0, 0);
    issue(1'b0, 1'b0, 11'h010, 8'h00);
    tick;
    reset_n = 1'b0;
    a_req = 1'b0;
    void'(sb.pop_back());
    a0 = a_acks;
    tick;
    check("t5_busy", {31'd0, busy}, 0);
    check("t5_rdata", {24'd0, a_rdata}, 0);
    check("t5_ack", {31'd0, a_ack}, 0);
    tick;
    tick;
    check("t5_no_ack", a_acks - a0, 0);
    reset_n = 1'b1;
    tick;
    issue(1'b0, 1'b0, 11'h010, 8'h00); run(1);
    check("t5_reissue", {24'd0, a_rdata}, 32'h11);
    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
